// File: rtl/tweezer_pi_sequencer_if.sv
// Host, photodiode and PI-controller signals seen by the tweezer PI sequencer.
interface tweezer_pi_sequencer_if #(
    parameter int inputBitSize = 16
);
    logic                    host_start;
    logic                    host_stop;
    logic [inputBitSize-1:0] sum;
    logic                    sum_valid;
    logic [inputBitSize-1:0] sum_threshold;
    logic [inputBitSize-1:0] pi_out;
    logic                    pi_out_valid;
    logic [inputBitSize-2:0] sat_limit;
    logic                    PI_reset;
    logic                    PI_enable;
    logic                    PI_freeze;
    logic [2:0]              state;
    logic                    bead_lost;
    logic                    fault;

    modport master (
        output host_start, host_stop, sum, sum_valid, sum_threshold,
               pi_out, pi_out_valid, sat_limit,
        input  PI_reset, PI_enable, PI_freeze, state, bead_lost, fault
    );

    modport slave (
        input  host_start, host_stop, sum, sum_valid, sum_threshold,
               pi_out, pi_out_valid, sat_limit,
        output PI_reset, PI_enable, PI_freeze, state, bead_lost, fault
    );
endinterface

// File: rtl/tweezer_pi_sequencer.sv
// Run-time sequencer driving PI_reset / PI_enable / PI_freeze of the tweezer loop.
// Define TWEEZER_SEQ_WATCHDOG_EN to add the sum_valid watchdog and the FAULT state.
module tweezer_pi_sequencer #(
    parameter int inputBitSize   = 16,
    parameter int ACQ_SAMPLES    = 8,
    parameter int LOSS_SAMPLES   = 4,
    parameter int RESET_CYCLES   = 4,
    parameter int SETTLE_SAMPLES = 16,
    parameter int WD_CYCLES      = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    tweezer_pi_sequencer_if.slave bus
);
    // state     | meaning
    // IDLE      | loop disarmed, PI held in reset
    // WAIT_BEAD | searching for ACQ_SAMPLES consecutive present samples
    // RESET_PI  | PI held in reset for RESET_CYCLES clocks
    // SETTLE    | PI running, waiting SETTLE_SAMPLES output strobes
    // LOCKED    | closed loop, integrator running
    // FROZEN    | closed loop, integrator frozen while output saturated
    // FAULT     | watchdog expired, only host_stop leaves
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_BEAD = 3'd1,
        S_RESET_PI  = 3'd2,
        S_SETTLE    = 3'd3,
        S_LOCKED    = 3'd4,
        S_FROZEN    = 3'd5,
        S_FAULT     = 3'd6
    } state_t;

    localparam int MAX_A = (ACQ_SAMPLES > LOSS_SAMPLES) ? ACQ_SAMPLES : LOSS_SAMPLES;
    localparam int MAX_B = (RESET_CYCLES > SETTLE_SAMPLES) ? RESET_CYCLES : SETTLE_SAMPLES;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_P = (MAX_C > WD_CYCLES) ? MAX_C : WD_CYCLES;
    localparam int CNT_W = $clog2(MAX_P + 1);

    localparam logic [CNT_W-1:0] ACQ_LAST    = CNT_W'(ACQ_SAMPLES - 1);
    localparam logic [CNT_W-1:0] LOSS_LAST   = CNT_W'(LOSS_SAMPLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_SAMPLES - 1);

    state_t                  state_q, state_nxt;
    logic [CNT_W-1:0]        acq_cnt, acq_nxt;
    logic [CNT_W-1:0]        loss_cnt, loss_nxt;
    logic [CNT_W-1:0]        rst_cnt, rst_nxt;
    logic [CNT_W-1:0]        settle_cnt, settle_nxt;
    logic                    lost_nxt;
    logic                    pi_reset_q, pi_enable_q, pi_freeze_q, bead_lost_q;
    logic                    present, sat;
    logic [inputBitSize-2:0] mag, mag_neg;

    // Negating only the low bits gives |pi_out| except for the most-negative code,
    // which clamps to full scale.
    assign mag_neg = ~bus.pi_out[inputBitSize-2:0] + 1'b1;
    assign mag     = !bus.pi_out[inputBitSize-1]       ? bus.pi_out[inputBitSize-2:0] :
                     (bus.pi_out[inputBitSize-2:0] == '0) ? '1 : mag_neg;

    assign present = bus.sum >= bus.sum_threshold;
    assign sat     = mag >= bus.sat_limit;

`ifdef TWEEZER_SEQ_WATCHDOG_EN
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WD_CYCLES - 1);
    logic [CNT_W-1:0] wd_cnt, wd_nxt;
    logic             fault_q;
`endif

    always_comb begin
        state_nxt  = state_q;
        acq_nxt    = acq_cnt;
        loss_nxt   = loss_cnt;
        rst_nxt    = rst_cnt;
        settle_nxt = settle_cnt;
        lost_nxt   = 1'b0;
`ifdef TWEEZER_SEQ_WATCHDOG_EN
        wd_nxt     = wd_cnt;
`endif
        if (bus.host_stop) begin
            state_nxt  = S_IDLE;
            acq_nxt    = '0;
            loss_nxt   = '0;
            rst_nxt    = '0;
            settle_nxt = '0;
`ifdef TWEEZER_SEQ_WATCHDOG_EN
            wd_nxt     = '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.host_start) begin
                        state_nxt = S_WAIT_BEAD;
                        acq_nxt   = '0;
                    end
                end
                S_WAIT_BEAD: begin
                    if (bus.sum_valid) begin
                        if (!present) begin
                            acq_nxt = '0;
                        end else if (acq_cnt >= ACQ_LAST) begin
                            state_nxt = S_RESET_PI;
                            acq_nxt   = '0;
                            rst_nxt   = '0;
                        end else begin
                            acq_nxt = acq_cnt + 1'b1;
                        end
                    end
                end
                S_RESET_PI: begin
                    if (rst_cnt >= RST_LAST) begin
                        state_nxt  = S_SETTLE;
                        rst_nxt    = '0;
                        settle_nxt = '0;
                        loss_nxt   = '0;
                    end else begin
                        rst_nxt = rst_cnt + 1'b1;
                    end
                end
                S_SETTLE: begin
                    // A bead drop outranks a settle completion in the same cycle.
                    if (bus.sum_valid && !present) begin
                        state_nxt  = S_WAIT_BEAD;
                        acq_nxt    = '0;
                        settle_nxt = '0;
                    end else if (bus.pi_out_valid) begin
                        if (settle_cnt >= SETTLE_LAST) begin
                            state_nxt  = S_LOCKED;
                            settle_nxt = '0;
                            loss_nxt   = '0;
                        end else begin
                            settle_nxt = settle_cnt + 1'b1;
                        end
                    end
                end
                S_LOCKED, S_FROZEN: begin
                    if (bus.sum_valid) begin
                        if (present) begin
                            loss_nxt = '0;
                        end else if (loss_cnt >= LOSS_LAST) begin
                            state_nxt = S_WAIT_BEAD;
                            loss_nxt  = '0;
                            acq_nxt   = '0;
                            lost_nxt  = 1'b1;
                        end else begin
                            loss_nxt = loss_cnt + 1'b1;
                        end
                    end
                    if (!lost_nxt && bus.pi_out_valid) begin
                        if (state_q == S_LOCKED && sat) begin
                            state_nxt = S_FROZEN;
                        end else if (state_q == S_FROZEN && !sat) begin
                            state_nxt = S_LOCKED;
                        end
                    end
                end
                S_FAULT: begin
                    state_nxt = S_FAULT;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
`ifdef TWEEZER_SEQ_WATCHDOG_EN
            if (state_q inside {S_SETTLE, S_LOCKED, S_FROZEN}) begin
                if (bus.sum_valid) begin
                    wd_nxt = '0;
                end else if (wd_cnt >= WD_LAST) begin
                    state_nxt = S_FAULT;
                    wd_nxt    = '0;
                end else begin
                    wd_nxt = wd_cnt + 1'b1;
                end
            end else begin
                wd_nxt = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            acq_cnt     <= '0;
            loss_cnt    <= '0;
            rst_cnt     <= '0;
            settle_cnt  <= '0;
            pi_reset_q  <= 1'b1;
            pi_enable_q <= 1'b0;
            pi_freeze_q <= 1'b0;
            bead_lost_q <= 1'b0;
`ifdef TWEEZER_SEQ_WATCHDOG_EN
            wd_cnt      <= '0;
            fault_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_nxt;
            acq_cnt     <= acq_nxt;
            loss_cnt    <= loss_nxt;
            rst_cnt     <= rst_nxt;
            settle_cnt  <= settle_nxt;
            pi_reset_q  <= state_nxt inside {S_IDLE, S_WAIT_BEAD, S_RESET_PI, S_FAULT};
            pi_enable_q <= state_nxt inside {S_SETTLE, S_LOCKED, S_FROZEN};
            pi_freeze_q <= state_nxt == S_FROZEN;
            bead_lost_q <= lost_nxt;
`ifdef TWEEZER_SEQ_WATCHDOG_EN
            wd_cnt      <= wd_nxt;
            fault_q     <= state_nxt == S_FAULT;
`endif
        end
    end

    assign bus.state     = state_q;
    assign bus.PI_reset  = pi_reset_q;
    assign bus.PI_enable = pi_enable_q;
    assign bus.PI_freeze = pi_freeze_q;
    assign bus.bead_lost = bead_lost_q;
`ifdef TWEEZER_SEQ_WATCHDOG_EN
    assign bus.fault     = fault_q;
`else
    assign bus.fault     = 1'b0;
`endif
endmodule
